// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE constants for the DSP slice MAC sequencer.
package dsp_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } token_t;

    localparam logic [7:0] OPM_MAC_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OPM_MAC_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OPM_HOLD      = 8'h08;  // X=0, Z=P

    function automatic logic [7:0] tok_opmode(token_t t);
        if (!t.valid)
            return OPM_HOLD;
        return t.first ? OPM_MAC_FIRST : OPM_MAC_ACC;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Token delay line mirroring the slice datapath latency; taps feed OPMODE and result flag.
module dsp_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int OPM_TAP = 1,
    parameter int RES_TAP = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  token_t push,
    output token_t opm_tok,
    output token_t res_tok
);

    token_t [DEPTH-1:0] tok_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tok_pipe <= '0;
        else if (clr)
            tok_pipe <= '0;
        else
            tok_pipe <= {tok_pipe[DEPTH-2:0], push};
    end

    assign opm_tok = tok_pipe[OPM_TAP];
    assign res_tok = tok_pipe[RES_TAP];

endmodule

// File: rtl/dsp_mac_seq.sv
// MAC sequencer driving DSP48A1-style slice CEs/OPMODE; P ends holding the sum of N products.
// Optional abort input and FLUSH state enabled by defining DSP_MAC_SEQ_ABORT_EN.
module dsp_mac_seq
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int A_LAT     = 1,
    parameter int MREG      = 1,
    parameter int OPMODEREG = 0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DSP_MAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             dsp_ce_ab,
    output logic             dsp_ce_m,
    output logic             dsp_ce_p,
    output logic             dsp_ce_opmode,
    output logic [7:0]       dsp_opmode,
    output logic             res_valid,
    output logic             busy
);

    localparam int T       = A_LAT + MREG - 1 - OPMODEREG;
    localparam int D       = A_LAT + MREG + 1;
    localparam int OPM_TAP = (T < 0) ? 0 : T;

    if (T < 0) begin : g_bad_cfg
        $error("dsp_mac_seq: A_LAT+MREG-1-OPMODEREG must be >= 0");
    end

    state_t           state, state_nxt;
    logic [LEN_W-1:0] rem;
    logic             first_pend;
    logic             cmd_acc, op_acc, is_last, act, abort_hit;
    token_t           push_tok, opm_tok, res_tok;
    logic             unused_tok;

    assign cmd_acc = cmd_valid & cmd_ready;
    assign op_acc  = op_valid & op_ready;
    assign is_last = (rem == LEN_W'(1));
    assign act     = (state == RUN) || (state == DRAIN);

`ifdef DSP_MAC_SEQ_ABORT_EN
    assign abort_hit = abort & act;
`else
    assign abort_hit = 1'b0;
`endif

    assign push_tok = '{valid: op_acc, first: op_acc & first_pend, last: op_acc & is_last};

    dsp_tag_pipe #(
        .DEPTH  (D),
        .OPM_TAP(OPM_TAP),
        .RES_TAP(D - 1)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort_hit || (state == FLUSH)),
        .push   (push_tok),
        .opm_tok(opm_tok),
        .res_tok(res_tok)
    );

    assign unused_tok = ^{opm_tok.last, res_tok.first};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready     = (state == IDLE);
        op_ready      = (state == RUN);
        busy          = (state != IDLE);
        dsp_ce_m      = act;
        dsp_ce_p      = act;
        dsp_ce_opmode = act;
        dsp_opmode    = act ? tok_opmode(opm_tok) : OPM_HOLD;
        res_valid     = (state == DRAIN) && res_tok.valid && res_tok.last && !abort_hit;
        case (state)
            IDLE:    if (cmd_acc && cmd_len != '0) state_nxt = RUN;
            RUN:     if (op_acc && is_last)        state_nxt = DRAIN;
            DRAIN:   if (res_valid)                state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
        // abort beats a coincident last-operand accept
        if (abort_hit)
            state_nxt = FLUSH;
    end

    assign dsp_ce_ab = op_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem        <= '0;
            first_pend <= 1'b0;
        end else if (cmd_acc) begin
            rem        <= cmd_len;
            first_pend <= 1'b1;
        end else if (op_acc) begin
            rem        <= rem - LEN_W'(1);
            first_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP slice model (A_LAT=1, MREG=1, PREG=1).
module tb_dsp_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, op_valid;
    logic [15:0] cmd_len;
    logic        cmd_ready, op_ready, res_valid, busy;
    logic        ce_ab, ce_m, ce_p, ce_opm;
    logic [7:0]  opmode;
`ifdef DSP_MAC_SEQ_ABORT_EN
    logic        abort;
`endif

    // slice model state
    logic [7:0]  a_in, b_in, a_r, b_r;
    logic [31:0] m_r, p_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsp_mac_seq dut (
        .clk          (clk),
        .rst          (rst),
`ifdef DSP_MAC_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .dsp_ce_ab    (ce_ab),
        .dsp_ce_m     (ce_m),
        .dsp_ce_p     (ce_p),
        .dsp_ce_opmode(ce_opm),
        .dsp_opmode   (opmode),
        .res_valid    (res_valid),
        .busy         (busy)
    );

    always @(posedge clk) begin
        if (rst) begin
            a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0;
        end else begin
            if (ce_ab) begin a_r <= a_in; b_r <= b_in; end
            if (ce_m) m_r <= 32'(a_r) * 32'(b_r);
            if (ce_p) p_r <= ((opmode[1:0] == 2'b01) ? m_r : 32'd0) +
                             ((opmode[3:2] == 2'b10) ? p_r : 32'd0);
        end
    end

    typedef struct {
        int         len;
        logic [7:0] mask;      // op_valid per cycle after command accept
        int         a [4];
        int         b [4];
        logic [7:0] opm [8];   // expected opmode, cycles 0..7
        int         res_cyc;
        int         p;
    } vec_t;

    vec_t vec [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {cmd_ready, op_ready, ce_ab, ce_m, ce_p, ce_opm, opmode, res_valid, busy},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0});
    endtask

    task automatic run_vec(input int k);
        int idx = 0;
        int res_seen = -1;
        int res_cnt = 0;
        logic [31:0] p_at_res = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 16'(vec[k].len);
        #1 check($sformatf("v%0d_cmd_ready", k), cmd_ready, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            op_valid  = vec[k].mask[c % 8] && (c < 8) && (idx < vec[k].len);
            a_in      = (idx < 4) ? 8'(vec[k].a[idx]) : 8'd0;
            b_in      = (idx < 4) ? 8'(vec[k].b[idx]) : 8'd0;
            #1;
            if (c < 8)
                check($sformatf("v%0d_opm_c%0d", k, c), opmode, vec[k].opm[c]);
            if (res_valid) begin
                res_cnt++;
                res_seen = c;
                p_at_res = p_r;
            end
            if (c == vec[k].res_cyc + 1)
                check($sformatf("v%0d_idle_after", k), {cmd_ready, busy}, 2'b10);
            if (op_valid && op_ready)
                idx++;
        end
        op_valid = 1'b0;
        check($sformatf("v%0d_res_cnt", k), res_cnt, 1);
        check($sformatf("v%0d_res_cyc", k), res_seen, vec[k].res_cyc);
        check($sformatf("v%0d_p", k), p_at_res, vec[k].p);
    endtask

    initial begin
        int errs;
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
        a_in = '0; b_in = '0;
`ifdef DSP_MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        vec[0].len = 4; vec[0].mask = 8'hFF; vec[0].a = '{1, 2, 3, 4}; vec[0].b = '{5, 6, 7, 8};
        vec[0].opm = '{8'h08, 8'h08, 8'h01, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08};
        vec[0].res_cyc = 6; vec[0].p = 70;
        vec[1].len = 2; vec[1].mask = 8'h05; vec[1].a = '{2, 3, 0, 0}; vec[1].b = '{4, 5, 0, 0};
        vec[1].opm = '{8'h08, 8'h08, 8'h01, 8'h08, 8'h09, 8'h08, 8'h08, 8'h08};
        vec[1].res_cyc = 5; vec[1].p = 23;
        vec[2].len = 3; vec[2].mask = 8'h16; vec[2].a = '{1, 2, 3, 0}; vec[2].b = '{1, 1, 1, 0};
        vec[2].opm = '{8'h08, 8'h08, 8'h08, 8'h01, 8'h09, 8'h08, 8'h09, 8'h08};
        vec[2].res_cyc = 7; vec[2].p = 6;
        vec[3].len = 1; vec[3].mask = 8'hFF; vec[3].a = '{3, 0, 0, 0}; vec[3].b = '{3, 0, 0, 0};
        vec[3].opm = '{8'h08, 8'h08, 8'h01, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
        vec[3].res_cyc = 3; vec[3].p = 9;
        vec[4].len = 1; vec[4].mask = 8'hFF; vec[4].a = '{2, 0, 0, 0}; vec[4].b = '{2, 0, 0, 0};
        vec[4].opm = '{8'h08, 8'h08, 8'h01, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
        vec[4].res_cyc = 3; vec[4].p = 4;

        repeat (3) @(negedge clk);
        #1 check_reset_vals("reset_vals");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++)
            run_vec(k);

        // zero-length command is swallowed
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = '0;
        #1 check("len0_ready", cmd_ready, 1'b1);
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1 if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) errs++;
        end
        check("len0_idle", errs, 0);

        // reset after two of five operands
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 16'd5; a_in = 8'd1; b_in = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0; op_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_vals("midrst_vals0");
        @(negedge clk);
        #1 check_reset_vals("midrst_vals1");
        rst = 1'b0; op_valid = 1'b0;
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1 if (res_valid !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("midrst_quiet", errs, 0);

`ifdef DSP_MAC_SEQ_ABORT_EN
        // abort after two of four operands
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 16'd4;
        @(negedge clk);
        cmd_valid = 1'b0; op_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 check("abort_flush", {op_ready, busy, cmd_ready, ce_m, ce_p, ce_opm, opmode},
                 {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08});
        @(negedge clk);
        op_valid = 1'b0;
        #1 check("abort_idle", {cmd_ready, busy}, 2'b10);
        errs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 if (res_valid !== 1'b0) errs++;
        end
        check("abort_no_res", errs, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
